// File: rtl/riscv_irq_ctrl_defs.sv
// Shared constants for the interrupt controller: register offsets, claim
// sentinel, AXI response codes and small bit-manipulation helpers.
package riscv_irq_ctrl_defs;

    localparam logic [4:0] OFF_PENDING = 5'h00;
    localparam logic [4:0] OFF_ENABLE  = 5'h04;
    localparam logic [4:0] OFF_MODE    = 5'h08;
    localparam logic [4:0] OFF_ACTIVE  = 5'h0C;
    localparam logic [4:0] OFF_RAW     = 5'h10;
    localparam logic [4:0] OFF_CLAIM   = 5'h14;

    localparam logic [31:0] CLAIM_NONE = 32'h8000_0000;

    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_SLVERR = 2'd2;

    function automatic logic [31:0] strb_mask(input logic [3:0] strb);
        return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    endfunction

    // Scans downward so the last hit is the lowest set bit.
    function automatic logic [31:0] claim_index(input logic [31:0] active);
        logic [31:0] idx;
        idx = CLAIM_NONE;
        for (int i = 31; i >= 0; i--) begin
            if (active[i]) begin
                idx = {27'd0, i[4:0]};
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/axi4lite_reg_if.sv
// AXI4-Lite slave front end: one-entry AW/W buffers, single outstanding
// read and write, exposing a simple register write strobe and read port.
module axi4lite_reg_if
    import riscv_irq_ctrl_defs::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        inport_awvalid_i,
    input  logic [31:0] inport_awaddr_i,
    input  logic        inport_wvalid_i,
    input  logic [31:0] inport_wdata_i,
    input  logic [3:0]  inport_wstrb_i,
    input  logic        inport_bready_i,
    input  logic        inport_arvalid_i,
    input  logic [31:0] inport_araddr_i,
    input  logic        inport_rready_i,
    output logic        inport_awready_o,
    output logic        inport_wready_o,
    output logic        inport_arready_o,
    output logic        inport_bvalid_o,
    output logic [1:0]  inport_bresp_o,
    output logic        inport_rvalid_o,
    output logic [31:0] inport_rdata_o,
    output logic [1:0]  inport_rresp_o,
    output logic        wr_en_o,
    output logic [2:0]  wr_addr_o,
    output logic [31:0] wr_data_o,
    output logic [3:0]  wr_strb_o,
    input  logic        wr_err_i,
    output logic [2:0]  rd_addr_o,
    input  logic [31:0] rd_data_i,
    input  logic        rd_err_i
);

    logic        aw_held_q, w_held_q, bvalid_q, rvalid_q;
    logic [2:0]  aw_addr_q;
    logic [31:0] w_data_q, rdata_q;
    logic [3:0]  w_strb_q;
    logic [1:0]  bresp_q, rresp_q;
    logic        aw_hs, w_hs, rd_en;
    logic        unused_addr;

    assign unused_addr = ^{inport_awaddr_i[31:5], inport_awaddr_i[1:0],
                           inport_araddr_i[31:5], inport_araddr_i[1:0]};

    assign inport_awready_o = ~aw_held_q & ~bvalid_q;
    assign inport_wready_o  = ~w_held_q & ~bvalid_q;
    assign inport_arready_o = ~rvalid_q;
    assign inport_bvalid_o  = bvalid_q;
    assign inport_bresp_o   = bresp_q;
    assign inport_rvalid_o  = rvalid_q;
    assign inport_rdata_o   = rdata_q;
    assign inport_rresp_o   = rresp_q;

    assign aw_hs = inport_awvalid_i & inport_awready_o;
    assign w_hs  = inport_wvalid_i & inport_wready_o;
    assign rd_en = inport_arvalid_i & inport_arready_o;

    // A write fires as soon as both halves are available, buffered or live.
    assign wr_en_o   = (aw_held_q | aw_hs) & (w_held_q | w_hs);
    assign wr_addr_o = aw_held_q ? aw_addr_q : inport_awaddr_i[4:2];
    assign wr_data_o = w_held_q ? w_data_q : inport_wdata_i;
    assign wr_strb_o = w_held_q ? w_strb_q : inport_wstrb_i;
    assign rd_addr_o = inport_araddr_i[4:2];

    // Channel buffers and response registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            aw_addr_q <= 3'd0;
            w_data_q  <= 32'd0;
            w_strb_q  <= 4'd0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            rvalid_q  <= 1'b0;
            rdata_q   <= 32'd0;
            rresp_q   <= RESP_OKAY;
        end else begin
            if (wr_en_o) begin
                aw_held_q <= 1'b0;
                w_held_q  <= 1'b0;
                bvalid_q  <= 1'b1;
                bresp_q   <= wr_err_i ? RESP_SLVERR : RESP_OKAY;
            end else begin
                if (aw_hs) begin
                    aw_held_q <= 1'b1;
                    aw_addr_q <= inport_awaddr_i[4:2];
                end
                if (w_hs) begin
                    w_held_q <= 1'b1;
                    w_data_q <= inport_wdata_i;
                    w_strb_q <= inport_wstrb_i;
                end
                if (bvalid_q & inport_bready_i) begin
                    bvalid_q <= 1'b0;
                end
            end
            if (rd_en) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_err_i ? 32'd0 : rd_data_i;
                rresp_q  <= rd_err_i ? RESP_SLVERR : RESP_OKAY;
            end else if (rvalid_q & inport_rready_i) begin
                rvalid_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/riscv_irq_ctrl.sv
// Interrupt controller: level/edge sources with pending, enable and mode
// registers, a lowest-index claim register and a registered CPU interrupt.
module riscv_irq_ctrl
    import riscv_irq_ctrl_defs::*;
#(
    parameter int          NUM_IRQ    = 8,
    parameter logic [31:0] EDGE_RESET = 32'h0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic               inport_awvalid_i,
    input  logic [31:0]        inport_awaddr_i,
    input  logic               inport_wvalid_i,
    input  logic [31:0]        inport_wdata_i,
    input  logic [3:0]         inport_wstrb_i,
    input  logic               inport_bready_i,
    input  logic               inport_arvalid_i,
    input  logic [31:0]        inport_araddr_i,
    input  logic               inport_rready_i,
    output logic               inport_awready_o,
    output logic               inport_wready_o,
    output logic               inport_arready_o,
    output logic               inport_bvalid_o,
    output logic [1:0]         inport_bresp_o,
    output logic               inport_rvalid_o,
    output logic [31:0]        inport_rdata_o,
    output logic [1:0]         inport_rresp_o,
    output logic               intr_o
);

    localparam logic [31:0] IRQ_MASK = (NUM_IRQ >= 32) ? 32'hFFFF_FFFF
                                     : ((32'd1 << NUM_IRQ) - 32'd1);

    logic        wr_en, wr_err, rd_err;
    logic [2:0]  wr_addr, rd_addr;
    logic [31:0] wr_data, rd_data;
    logic [3:0]  wr_strb;

    logic [31:0] irq_ext, irq_q, irq_prev_q;
    logic [31:0] pending_q, pending_d, enable_q, enable_d, mode_q, mode_d;
    logic [31:0] wmask, wbits, w1c, active;
    logic        intr_q;

    axi4lite_reg_if u_axi (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .inport_awvalid_i (inport_awvalid_i),
        .inport_awaddr_i  (inport_awaddr_i),
        .inport_wvalid_i  (inport_wvalid_i),
        .inport_wdata_i   (inport_wdata_i),
        .inport_wstrb_i   (inport_wstrb_i),
        .inport_bready_i  (inport_bready_i),
        .inport_arvalid_i (inport_arvalid_i),
        .inport_araddr_i  (inport_araddr_i),
        .inport_rready_i  (inport_rready_i),
        .inport_awready_o (inport_awready_o),
        .inport_wready_o  (inport_wready_o),
        .inport_arready_o (inport_arready_o),
        .inport_bvalid_o  (inport_bvalid_o),
        .inport_bresp_o   (inport_bresp_o),
        .inport_rvalid_o  (inport_rvalid_o),
        .inport_rdata_o   (inport_rdata_o),
        .inport_rresp_o   (inport_rresp_o),
        .wr_en_o          (wr_en),
        .wr_addr_o        (wr_addr),
        .wr_data_o        (wr_data),
        .wr_strb_o        (wr_strb),
        .wr_err_i         (wr_err),
        .rd_addr_o        (rd_addr),
        .rd_data_i        (rd_data),
        .rd_err_i         (rd_err)
    );

    assign wr_err = (wr_addr[2:1] == 2'b11);
    assign rd_err = (rd_addr[2:1] == 2'b11);
    assign wmask  = strb_mask(wr_strb) & IRQ_MASK;
    assign wbits  = wr_data & wmask;
    assign active = pending_q & enable_q;
    assign intr_o = intr_q;

    // Zero-extend the sources to the 32-bit register width.
    always_comb begin
        irq_ext = 32'd0;
        irq_ext[NUM_IRQ-1:0] = irq_i;
    end

    // Register next-state; a newly edge-mode bit starts cleared, set beats W1C.
    always_comb begin
        enable_d = enable_q;
        mode_d   = mode_q;
        w1c      = 32'd0;
        if (wr_en && ({wr_addr, 2'b00} == OFF_ENABLE)) begin
            enable_d = (enable_q & ~wmask) | wbits;
        end else begin
            enable_d = enable_q;
        end
        if (wr_en && ({wr_addr, 2'b00} == OFF_MODE)) begin
            mode_d = (mode_q & ~wmask) | wbits;
        end else begin
            mode_d = mode_q;
        end
        if (wr_en && ({wr_addr, 2'b00} == OFF_PENDING)) begin
            w1c = wbits;
        end else begin
            w1c = 32'd0;
        end
        pending_d = (~mode_d & irq_q)
                  | (mode_d & mode_q & ((irq_q & ~irq_prev_q) | (pending_q & ~w1c)));
    end

    // Read data mux.
    always_comb begin
        rd_data = 32'd0;
        case ({rd_addr, 2'b00})
            OFF_PENDING: rd_data = pending_q;
            OFF_ENABLE:  rd_data = enable_q;
            OFF_MODE:    rd_data = mode_q;
            OFF_ACTIVE:  rd_data = active;
            OFF_RAW:     rd_data = irq_q;
            OFF_CLAIM:   rd_data = claim_index(active);
            default:     rd_data = 32'd0;
        endcase
    end

    // Interrupt state registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            irq_q      <= 32'd0;
            irq_prev_q <= 32'd0;
            pending_q  <= 32'd0;
            enable_q   <= 32'd0;
            mode_q     <= EDGE_RESET & IRQ_MASK;
            intr_q     <= 1'b0;
        end else begin
            irq_q      <= irq_ext;
            irq_prev_q <= irq_q;
            pending_q  <= pending_d;
            enable_q   <= enable_d;
            mode_q     <= mode_d;
            intr_q     <= |active;
        end
    end

endmodule

// File: tb/tb_riscv_irq_ctrl.sv
// Directed bench for riscv_irq_ctrl: a register-access vector table followed
// by hand-written interrupt, handshake and reset sequences.
module tb_riscv_irq_ctrl;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic [7:0]  irq_i = 8'd0;
    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic [31:0] awaddr = 32'd0, wdata = 32'd0, araddr = 32'd0;
    logic [3:0]  wstrb = 4'd0;
    logic        awready, wready, arready, bvalid, rvalid, intr;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;

    int errors = 0;
    int checks = 0;

    riscv_irq_ctrl #(.NUM_IRQ(8), .EDGE_RESET(32'h0)) dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .irq_i            (irq_i),
        .inport_awvalid_i (awvalid),
        .inport_awaddr_i  (awaddr),
        .inport_wvalid_i  (wvalid),
        .inport_wdata_i   (wdata),
        .inport_wstrb_i   (wstrb),
        .inport_bready_i  (bready),
        .inport_arvalid_i (arvalid),
        .inport_araddr_i  (araddr),
        .inport_rready_i  (rready),
        .inport_awready_o (awready),
        .inport_wready_o  (wready),
        .inport_arready_o (arready),
        .inport_bvalid_o  (bvalid),
        .inport_bresp_o   (bresp),
        .inport_rvalid_o  (rvalid),
        .inport_rdata_o   (rdata),
        .inport_rresp_o   (rresp),
        .intr_o           (intr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_write;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, output logic [1:0] resp);
        bit aw_done, w_done, aw_hs, w_hs, got;
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        aw_done = 1'b0; w_done = 1'b0;
        for (int n = 0; n < 20 && !(aw_done && w_done); n++) begin
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            tick();
            if (aw_hs) begin aw_done = 1'b1; awvalid = 1'b0; end
            if (w_hs)  begin w_done  = 1'b1; wvalid  = 1'b0; end
        end
        awvalid = 1'b0; wvalid = 1'b0;
        got = 1'b0; resp = 2'b11;
        for (int n = 0; n < 20 && !got; n++) begin
            if (bvalid) begin got = 1'b1; resp = bresp; end
            tick();
        end
        bready = 1'b0;
        if (!got) begin
            checks++; errors++;
            $display("FAIL write_timeout: no bvalid for addr 0x%08h", a);
        end
    endtask

    task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
        bit done, hs, got;
        araddr = a; arvalid = 1'b1; rready = 1'b1; done = 1'b0;
        for (int n = 0; n < 20 && !done; n++) begin
            hs = arready;
            tick();
            if (hs) begin done = 1'b1; arvalid = 1'b0; end
        end
        arvalid = 1'b0;
        got = 1'b0; d = 32'hDEAD_BEEF; r = 2'b11;
        for (int n = 0; n < 20 && !got; n++) begin
            if (rvalid) begin got = 1'b1; d = rdata; r = rresp; end
            tick();
        end
        rready = 1'b0;
        if (!got) begin
            checks++; errors++;
            $display("FAIL read_timeout: no rvalid for addr 0x%08h", a);
        end
    endtask

    task automatic read_check(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        logic [1:0]  r;
        axi_read(a, d, r);
        check(name, d, exp);
    endtask

    task automatic write_ok(input logic [31:0] a, input logic [31:0] d);
        logic [1:0] r;
        axi_write(a, d, 4'hF, r);
        check("write_resp", {30'd0, r}, 32'd0);
    endtask

    initial begin
        logic [31:0] d;
        logic [1:0]  r;

        vecs[0]  = '{1'b0, 32'h0000_0004, 32'h0, 4'h0, 32'h0000_0000, 2'd0};
        vecs[1]  = '{1'b0, 32'h0000_0008, 32'h0, 4'h0, 32'h0000_0000, 2'd0};
        vecs[2]  = '{1'b1, 32'h0000_0004, 32'hFFFF_FFFF, 4'hF, 32'h0, 2'd0};
        vecs[3]  = '{1'b0, 32'h0000_0004, 32'h0, 4'h0, 32'h0000_00FF, 2'd0};
        vecs[4]  = '{1'b1, 32'h0000_0004, 32'h0000_AB5A, 4'h1, 32'h0, 2'd0};
        vecs[5]  = '{1'b0, 32'h0000_0004, 32'h0, 4'h0, 32'h0000_005A, 2'd0};
        vecs[6]  = '{1'b1, 32'h0000_0004, 32'h0000_00FF, 4'h0, 32'h0, 2'd0};
        vecs[7]  = '{1'b0, 32'hFFFF_FFE4, 32'h0, 4'h0, 32'h0000_005A, 2'd0};
        vecs[8]  = '{1'b0, 32'h0000_0018, 32'h0, 4'h0, 32'h0000_0000, 2'd2};
        vecs[9]  = '{1'b1, 32'h0000_001C, 32'hFFFF_FFFF, 4'hF, 32'h0, 2'd2};
        vecs[10] = '{1'b0, 32'h0000_001C, 32'h0, 4'h0, 32'h0000_0000, 2'd2};
        vecs[11] = '{1'b0, 32'h0000_0014, 32'h0, 4'h0, 32'h8000_0000, 2'd0};
        vecs[12] = '{1'b0, 32'h0000_0010, 32'h0, 4'h0, 32'h0000_0000, 2'd0};
        vecs[13] = '{1'b1, 32'h0000_000C, 32'h0000_00FF, 4'hF, 32'h0, 2'd0};
        vecs[14] = '{1'b0, 32'h0000_000C, 32'h0, 4'h0, 32'h0000_0000, 2'd0};
        vecs[15] = '{1'b1, 32'h0000_0008, 32'h0000_0100, 4'hF, 32'h0, 2'd0};
        vecs[16] = '{1'b0, 32'h0000_0008, 32'h0, 4'h0, 32'h0000_0000, 2'd0};

        repeat (3) tick();
        rst_i = 1'b0;
        tick();
        check("rst_awready", {31'd0, awready}, 32'd1);
        check("rst_wready",  {31'd0, wready},  32'd1);
        check("rst_arready", {31'd0, arready}, 32'd1);
        check("rst_bvalid",  {31'd0, bvalid},  32'd0);
        check("rst_rvalid",  {31'd0, rvalid},  32'd0);
        check("rst_rdata",   rdata,            32'd0);
        check("rst_intr",    {31'd0, intr},    32'd0);

        for (int i = 0; i < 17; i++) begin
            if (vecs[i].is_write) begin
                axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, r);
                check($sformatf("vec%0d_bresp", i), {30'd0, r}, {30'd0, vecs[i].exp_resp});
            end else begin
                axi_read(vecs[i].addr, d, r);
                check($sformatf("vec%0d_rdata", i), d, vecs[i].exp_data);
                check($sformatf("vec%0d_rresp", i), {30'd0, r}, {30'd0, vecs[i].exp_resp});
            end
        end

        // Level mode: three-cycle latency both ways, W1C ignored.
        write_ok(32'h08, 32'h00);
        write_ok(32'h04, 32'h01);
        irq_i = 8'h01;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("lvl_rise_c%0d", k + 1), {31'd0, intr}, (k == 2) ? 32'd1 : 32'd0);
        end
        write_ok(32'h00, 32'h01);
        read_check("lvl_w1c_pending", 32'h00, 32'h01);
        check("lvl_w1c_intr", {31'd0, intr}, 32'd1);
        irq_i = 8'h00;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("lvl_fall_c%0d", k + 1), {31'd0, intr}, (k == 2) ? 32'd0 : 32'd1);
        end

        // Edge mode: a one-cycle pulse latches until cleared.
        write_ok(32'h08, 32'h04);
        write_ok(32'h04, 32'h04);
        irq_i = 8'h04;
        tick();
        irq_i = 8'h00;
        repeat (3) tick();
        check("edge_intr_set", {31'd0, intr}, 32'd1);
        read_check("edge_pending", 32'h00, 32'h04);
        repeat (2) tick();
        check("edge_intr_held", {31'd0, intr}, 32'd1);
        write_ok(32'h00, 32'h04);
        check("edge_intr_cleared", {31'd0, intr}, 32'd0);
        read_check("edge_pending_cleared", 32'h00, 32'h00);

        // W1C and a new edge on the same clock: the set must survive.
        irq_i = 8'h04;
        tick();
        awaddr = 32'h00; wdata = 32'h04; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0; irq_i = 8'h00;
        check("coll_bvalid", {31'd0, bvalid}, 32'd1);
        tick();
        bready = 1'b0;
        read_check("coll_pending", 32'h00, 32'h04);
        write_ok(32'h00, 32'h04);
        read_check("coll_pending_cleared", 32'h00, 32'h00);

        // Claim picks the lowest active index.
        write_ok(32'h08, 32'h00);
        write_ok(32'h04, 32'hFF);
        irq_i = 8'h28;
        repeat (3) tick();
        read_check("claim_active", 32'h0C, 32'h28);
        read_check("claim_raw", 32'h10, 32'h28);
        read_check("claim_idx", 32'h14, 32'h03);
        read_check("claim_idx_again", 32'h14, 32'h03);
        irq_i = 8'h00;
        repeat (3) tick();
        read_check("claim_none", 32'h14, 32'h8000_0000);

        // W ahead of AW by three cycles, response back-pressured for five.
        bready = 1'b0;
        wdata = 32'h0F; wstrb = 4'hF; wvalid = 1'b1;
        awaddr = 32'h04;
        check("hs_wready_idle", {31'd0, wready}, 32'd1);
        tick();
        wvalid = 1'b0;
        check("hs_wready_held", {31'd0, wready}, 32'd0);
        check("hs_awready_open", {31'd0, awready}, 32'd1);
        repeat (2) tick();
        check("hs_no_early_bvalid", {31'd0, bvalid}, 32'd0);
        awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("hs_bvalid_c%0d", k), {31'd0, bvalid}, 32'd1);
            check($sformatf("hs_awready_c%0d", k), {31'd0, awready}, 32'd0);
            check($sformatf("hs_wready_c%0d", k), {31'd0, wready}, 32'd0);
            tick();
        end
        check("hs_bresp", {30'd0, bresp}, 32'd0);
        bready = 1'b1;
        tick();
        bready = 1'b0;
        check("hs_bvalid_done", {31'd0, bvalid}, 32'd0);
        check("hs_awready_back", {31'd0, awready}, 32'd1);
        read_check("hs_enable", 32'h04, 32'h0F);

        // Reset while a read response is waiting.
        write_ok(32'h08, 32'h02);
        irq_i = 8'h01;
        repeat (3) tick();
        check("rst_pre_intr", {31'd0, intr}, 32'd1);
        araddr = 32'h04; arvalid = 1'b1; rready = 1'b0;
        tick();
        arvalid = 1'b0;
        check("rst_pre_rvalid", {31'd0, rvalid}, 32'd1);
        check("rst_pre_rdata", rdata, 32'h0F);
        tick();
        check("rst_rdata_stable", rdata, 32'h0F);
        rst_i = 1'b1;
        irq_i = 8'h00;
        tick();
        rst_i = 1'b0;
        check("mid_rst_rvalid", {31'd0, rvalid}, 32'd0);
        check("mid_rst_rdata",  rdata,           32'd0);
        check("mid_rst_intr",   {31'd0, intr},   32'd0);
        check("mid_rst_arready", {31'd0, arready}, 32'd1);
        read_check("post_rst_enable",  32'h04, 32'h00);
        read_check("post_rst_mode",    32'h08, 32'h00);
        read_check("post_rst_pending", 32'h00, 32'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
